dcp_run_ctrl: RTL and testbench

DCP_RUN_CTRL -- requirements
Module: dcp_run_ctrl

---
 rtl/dcp_pkg.sv | 37 +++
 rtl/dcp_bp_table.sv | 40 ++++
 rtl/dcp_run_ctrl.sv | 105 ++++++++++
 tb/tb_dcp_run_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dcp_pkg.sv
// Shared encodings for the debug-control-port run controller.
package dcp_pkg;

  localparam logic [31:0] CYC_LIMIT_DEF = 32'd1_000_000;

  // Run modes, sampled with start
  localparam logic [1:0] MODE_STEP = 2'b00;
  localparam logic [1:0] MODE_GO   = 2'b01;
  localparam logic [1:0] MODE_CYC  = 2'b10;
  localparam logic [1:0] MODE_RSV  = 2'b11;  // behaves as CYC

  // Halt reason codes
  localparam logic [1:0] HALT_DONE  = 2'd0;
  localparam logic [1:0] HALT_BRK   = 2'd1;
  localparam logic [1:0] HALT_ABORT = 2'd2;
  localparam logic [1:0] HALT_TMO   = 2'd3;

  // Controller states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HI   = 2'd1;
  localparam logic [1:0] ST_LO   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Breakpoint table write request
  typedef struct packed {
    logic        we;
    logic [1:0]  idx;
    logic        en;
    logic [31:0] addr;
  } bp_wr_t;

  // Increment that sticks at all-ones
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dcp_bp_table.sv
// Breakpoint table: NBP address/valid entries with a parallel compare
// against the CPU next-PC. Match is purely combinational.
module dcp_bp_table
  import dcp_pkg::*;
#(
  parameter int NBP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  bp_wr_t      wr,
  input  logic [31:0] npc,
  output logic        match
);

  logic [NBP-1:0] hit;

  for (genvar i = 0; i < NBP; i++) begin : g_ent
    logic        vld;
    logic [31:0] addr;
    logic        sel;

    assign sel = wr.we && (wr.idx == 2'(i));

    // Valid bit: cleared by reset, loaded on a write to this entry
    always_ff @(posedge clk) begin
      if (rst)      vld <= 1'b0;
      else if (sel) vld <= wr.en;
    end

    // Address needs no reset; it is qualified by the valid bit
    always_ff @(posedge clk) begin
      if (sel) addr <= wr.addr;
    end

    assign hit[i] = vld && (addr == npc);
  end

  assign match = |hit;

endmodule

// File: rtl/dcp_run_ctrl.sv
// Run controller: generates single CPU clock pulses (HI then LO) for
// STEP / GO / CYC runs, stops on abort, breakpoint, completion or timeout.
module dcp_run_ctrl
  import dcp_pkg::*;
#(
  parameter int          NBP       = 4,
  parameter logic [31:0] CYC_LIMIT = CYC_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic        abort,
  input  logic        bp_we,
  input  logic [1:0]  bp_idx,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic        pc_chk,
  input  logic [31:0] npc,
  output logic        clk_cpu,
  output logic        busy,
  output logic        done,
  output logic [1:0]  halt_rsn,
  output logic [31:0] instr_cnt
);

  logic [1:0]  state, state_nx;
  logic [1:0]  mode_q;
  logic [1:0]  rsn_nx;
  logic [31:0] cyc_cnt;
  logic        stop;
  logic        bp_hit;
  logic        is_go, is_step, is_cyc;
  bp_wr_t      bp_wr;

  // Table is frozen while a run is active
  assign bp_wr = '{we: bp_we && (state == ST_IDLE), idx: bp_idx,
                   en: bp_en, addr: bp_addr};

  dcp_bp_table #(.NBP(NBP)) u_bp (
    .clk   (clk),
    .rst   (rst),
    .wr    (bp_wr),
    .npc   (npc),
    .match (bp_hit)
  );

  assign is_go   = (mode_q == MODE_GO);
  assign is_step = (mode_q == MODE_STEP);
  assign is_cyc  = mode_q[1];  // CYC and reserved

  // Next state and stop decision; stop causes are tested in priority order
  always_comb begin
    state_nx = state;
    stop     = 1'b0;
    rsn_nx   = HALT_DONE;
    case (state)
      ST_IDLE: if (start) state_nx = ST_HI;
      ST_HI:   state_nx = ST_LO;
      ST_LO: begin
        stop = 1'b1;
        if (abort)                              rsn_nx = HALT_ABORT;
        else if (is_go && pc_chk && bp_hit)     rsn_nx = HALT_BRK;
        else if (is_cyc || (is_step && pc_chk)) rsn_nx = HALT_DONE;
        else if (cyc_cnt == CYC_LIMIT - 32'd1)  rsn_nx = HALT_TMO;
        else                                    stop   = 1'b0;
        state_nx = stop ? ST_DONE : ST_HI;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State, CPU clock pulse, mode latch, cycle counter and halt reason
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      clk_cpu  <= 1'b0;
      mode_q   <= MODE_STEP;
      cyc_cnt  <= 32'd0;
      halt_rsn <= HALT_DONE;
    end else begin
      state   <= state_nx;
      clk_cpu <= (state_nx == ST_HI);
      if (state == ST_IDLE && start) begin
        mode_q   <= mode;
        cyc_cnt  <= 32'd0;
        halt_rsn <= HALT_DONE;
      end
      if (state == ST_LO) begin
        if (stop) halt_rsn <= rsn_nx;
        else      cyc_cnt  <= cyc_cnt + 32'd1;
      end
    end
  end

  // Completed-instruction counter, counts the stopping cycle too
  always_ff @(posedge clk) begin
    if (rst)                          instr_cnt <= 32'd0;
    else if (state == ST_LO && pc_chk) instr_cnt <= sat_inc(instr_cnt);
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_dcp_run_ctrl.sv
// Self-checking bench for dcp_run_ctrl: directed scenarios plus randomized
// runs compared against a per-CPU-cycle reference model.
module tb_dcp_run_ctrl;
  import dcp_pkg::*;

  localparam int LIM = 16;

  logic        clk = 1'b0;
  logic        rst, start, abort, bp_we, bp_en, pc_chk;
  logic [1:0]  mode, bp_idx;
  logic [31:0] bp_addr, npc;
  logic        clk_cpu, busy, done;
  logic [1:0]  halt_rsn;
  logic [31:0] instr_cnt;

  int n_chk = 0;
  int n_err = 0;

  dcp_run_ctrl #(.NBP(4), .CYC_LIMIT(32'd16)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .bp_we(bp_we), .bp_idx(bp_idx), .bp_en(bp_en), .bp_addr(bp_addr),
    .pc_chk(pc_chk), .npc(npc), .clk_cpu(clk_cpu), .busy(busy),
    .done(done), .halt_rsn(halt_rsn), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  // Reference state
  bit          m_en   [4];
  logic [31:0] m_addr [4];
  logic [31:0] m_instr;
  // Per-CPU-cycle stimulus
  logic        s_chk  [LIM];
  logic        s_ab   [LIM];
  logic [31:0] s_npc  [LIM];
  logic [31:0] pool   [6];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_match(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if (m_en[i] && m_addr[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic bp_write(input int idx, input bit en, input logic [31:0] a);
    @(negedge clk);
    bp_we = 1'b1; bp_idx = 2'(idx); bp_en = en; bp_addr = a;
    @(negedge clk);
    bp_we = 1'b0;
    m_en[idx] = en; m_addr[idx] = a;
  endtask

  task automatic fill(input bit rnd, input logic [31:0] a, input logic c);
    for (int k = 0; k < LIM; k++) begin
      s_chk[k] = rnd ? 1'($urandom_range(0, 1)) : c;
      s_npc[k] = rnd ? pool[$urandom_range(0, 5)] : a;
      s_ab[k]  = rnd ? ($urandom_range(0, 19) == 0) : 1'b0;
    end
  endtask

  // One run: predict from the stimulus tables, drive, then compare.
  task automatic run(input string tag, input logic [1:0] md, input bit noise,
                     input bit mid_we, input logic [31:0] mid_addr);
    int          exp_p = 0;
    logic [1:0]  exp_r = HALT_DONE;
    logic [31:0] exp_i = m_instr;
    int          cyc = 0, pulses = 0;
    bit          seen = 1'b0;
    for (int k = 0; k < LIM; k++) begin
      exp_p = k + 1;
      if (s_chk[k] && exp_i != 32'hFFFF_FFFF) exp_i = exp_i + 32'd1;
      if (s_ab[k])                                     begin exp_r = HALT_ABORT; break; end
      if (md == MODE_GO && s_chk[k] && m_match(s_npc[k])) begin exp_r = HALT_BRK; break; end
      if (md[1] || (md == MODE_STEP && s_chk[k]))      begin exp_r = HALT_DONE; break; end
      if (k == LIM - 1) exp_r = HALT_TMO;
    end

    @(negedge clk);
    start = 1'b1; mode = md;
    while (!seen && cyc < 2 * LIM + 8) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; bp_we = 1'b0;
      if (noise) mode = 2'($urandom);
      if (done) seen = 1'b1;
      else if (clk_cpu) begin
        if (pulses < LIM) begin
          pc_chk = s_chk[pulses]; npc = s_npc[pulses]; abort = s_ab[pulses];
        end
        if (noise && $urandom_range(0, 2) == 0) start = 1'b1;
        if ((noise && $urandom_range(0, 2) == 0) || (mid_we && pulses == 0)) begin
          bp_we   = 1'b1;
          bp_en   = 1'b1;
          bp_idx  = mid_we ? 2'd2 : 2'($urandom);
          bp_addr = mid_we ? mid_addr : pool[$urandom_range(0, 5)];
        end
        pulses++;
      end
    end
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    chk({tag, " pulses"}, 32'(pulses), 32'(exp_p));
    chk({tag, " done_time"}, 32'(cyc), 32'(2 * exp_p + 1));
    chk({tag, " halt_rsn"}, 32'(halt_rsn), 32'(exp_r));
    chk({tag, " instr_cnt"}, instr_cnt, exp_i);
    abort = 1'b0; pc_chk = 1'b0;
    @(negedge clk);
    chk({tag, " done_1cyc"}, 32'(done), 32'd0);
    chk({tag, " idle"}, 32'(busy), 32'd0);
    m_instr = exp_i;
  endtask

  initial begin
    int dn;
    pool[0] = 32'h4;  pool[1] = 32'h8;  pool[2] = 32'hC;
    pool[3] = 32'h10; pool[4] = 32'h44; pool[5] = 32'h80;
    rst = 1'b1; start = 1'b0; mode = MODE_STEP; abort = 1'b0;
    bp_we = 1'b0; bp_idx = 2'd0; bp_en = 1'b0; bp_addr = 32'd0;
    pc_chk = 1'b0; npc = 32'd0;
    m_instr = 32'd0;
    for (int i = 0; i < 4; i++) begin m_en[i] = 1'b0; m_addr[i] = 32'd0; end
    repeat (3) @(negedge clk);
    chk("rst clk_cpu", 32'(clk_cpu), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst halt_rsn", 32'(halt_rsn), 32'd0);
    chk("rst instr_cnt", instr_cnt, 32'd0);
    rst = 1'b0;

    // abort while idle does nothing
    abort = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_abort busy", 32'(busy), 32'd0);
    chk("idle_abort clk_cpu", 32'(clk_cpu), 32'd0);
    abort = 1'b0;

    // STEP, instruction completes on the 3rd CPU cycle
    fill(1'b0, 32'h0, 1'b0);
    s_chk[2] = 1'b1;
    run("step3", MODE_STEP, 1'b0, 1'b0, 32'h0);

    // GO into breakpoint at 0x10 after 4 instructions
    bp_write(1, 1'b1, 32'h10);
    fill(1'b0, 32'h0, 1'b1);
    s_npc[0] = 32'h4; s_npc[1] = 32'h8; s_npc[2] = 32'hC; s_npc[3] = 32'h10;
    run("go_brk", MODE_GO, 1'b0, 1'b0, 32'h0);

    // GO with no valid breakpoints runs into timeout
    bp_write(1, 1'b0, 32'h10);
    fill(1'b0, 32'h10, 1'b1);
    run("go_tmo", MODE_GO, 1'b0, 1'b0, 32'h0);

    // abort and breakpoint match in the same CPU cycle
    bp_write(1, 1'b1, 32'h10);
    fill(1'b0, 32'h8, 1'b0);
    s_chk[2] = 1'b1; s_npc[2] = 32'h10; s_ab[2] = 1'b1;
    run("go_abort", MODE_GO, 1'b0, 1'b0, 32'h0);

    // breakpoint write during a run is dropped
    fill(1'b0, 32'h0, 1'b0);
    run("go_midwr", MODE_GO, 1'b0, 1'b1, 32'h44);
    fill(1'b0, 32'h44, 1'b1);
    run("go_nobrk", MODE_GO, 1'b0, 1'b0, 32'h0);

    // single CPU cycle modes
    fill(1'b0, 32'h10, 1'b1);
    run("cyc", MODE_CYC, 1'b0, 1'b0, 32'h0);
    run("rsv", MODE_RSV, 1'b0, 1'b0, 32'h0);

    // randomized runs with start/mode/bp_we noise while busy
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 2) == 0)
        bp_write($urandom_range(0, 3), 1'($urandom_range(0, 1)), pool[$urandom_range(0, 5)]);
      fill(1'b1, 32'h0, 1'b0);
      run("rand", 2'($urandom), 1'b1, 1'b0, 32'h0);
    end

    // reset during HI of a GO run
    bp_write(0, 1'b1, 32'h10);
    @(negedge clk);
    start = 1'b1; mode = MODE_GO;
    @(negedge clk);
    start = 1'b0;
    chk("mid_rst pre clk_cpu", 32'(clk_cpu), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst clk_cpu", 32'(clk_cpu), 32'd0);
    chk("mid_rst busy", 32'(busy), 32'd0);
    chk("mid_rst done", 32'(done), 32'd0);
    chk("mid_rst halt_rsn", 32'(halt_rsn), 32'd0);
    chk("mid_rst instr_cnt", instr_cnt, 32'd0);
    rst = 1'b0;
    m_instr = 32'd0;
    for (int i = 0; i < 4; i++) m_en[i] = 1'b0;
    dn = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || clk_cpu) dn++;
    end
    chk("mid_rst quiet", 32'(dn), 32'd0);
    // breakpoints were invalidated by reset
    fill(1'b0, 32'h10, 1'b1);
    run("post_rst", MODE_GO, 1'b0, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
